mux2to1_param: RTL and testbench



---
 rtl/mux2to1_param_pkg.sv | 10 +
 rtl/mux2to1_param.sv | 64 ++++++
 tb/tb_mux2to1_param.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux2to1_param_pkg.sv
// ----------------------------------------------------------------------------
// mux2to1_param_pkg
// Shared constants for the parameterised 2-to-1 word multiplexer.
//   DEFAULT_WIDTH : data width used when an instance does not override WIDTH
// ----------------------------------------------------------------------------
package mux2to1_param_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

endpackage : mux2to1_param_pkg

// File: rtl/mux2to1_param.sv
// ----------------------------------------------------------------------------
// mux2to1_param
// Parameterised 2-to-1 word multiplexer for operand and write-back selection.
// A combinational result is available with zero latency. A registered copy of
// the result and of the select line is provided for consumers that need a
// flop boundary.
//
// Ports
//   clk       in   1      rising-edge clock for the registered outputs
//   rst_n     in   1      asynchronous, active-low reset of the registers
//   entrada0  in   WIDTH  data selected when sel is not 1
//   entrada1  in   WIDTH  data selected when sel is 1
//   sel       in   1      select line
//   salida    out  WIDTH  combinational mux result (never reset)
//   salida_q  out  WIDTH  salida registered on clk
//   sel_q     out  1      sel registered on clk
// ----------------------------------------------------------------------------
module mux2to1_param
   import mux2to1_param_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] entrada0,
   input  logic [WIDTH-1:0] entrada1,
   input  logic             sel,
   output logic [WIDTH-1:0] salida,
   output logic [WIDTH-1:0] salida_q,
   output logic             sel_q
);

   logic [WIDTH-1:0] w_muxOut;
   logic [WIDTH-1:0] r_salidaQ;
   logic             r_selQ;

   // Combinational select. Written as an if/else so that any sel value that
   // is not a clean 1 (including X/Z in simulation) falls through to
   // entrada0, rather than producing a bitwise merge of both inputs.
   always_comb begin
      w_muxOut = entrada0;
      if (sel == 1'b1) begin
         w_muxOut = entrada1;
      end
   end

   // Output register for consumers needing a flop boundary. Reset clears
   // both registered outputs immediately on the falling edge of rst_n,
   // independent of clk; the combinational result is not affected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_salidaQ <= '0;
         r_selQ    <= 1'b0;
      end else begin
         r_salidaQ <= w_muxOut;
         r_selQ    <= sel;
      end
   end

   assign salida   = w_muxOut;
   assign salida_q = r_salidaQ;
   assign sel_q    = r_selQ;

endmodule : mux2to1_param

// File: tb/tb_mux2to1_param.sv
// ----------------------------------------------------------------------------
// tb_mux2to1_param
// Directed self-checking bench for mux2to1_param: a default-width (32-bit)
// instance plus WIDTH = 8 and WIDTH = 1 instances sharing clock and reset.
// ----------------------------------------------------------------------------
module tb_mux2to1_param;

   logic        clk;
   logic        clkEnable;
   logic        rst_n;

   logic [31:0] entrada0;
   logic [31:0] entrada1;
   logic        sel;
   logic [31:0] salida;
   logic [31:0] salidaQ;
   logic        selQ;

   logic [7:0]  entrada0w8;
   logic [7:0]  entrada1w8;
   logic        selW8;
   logic [7:0]  salidaW8;
   logic [7:0]  salidaQW8;
   logic        selQW8;

   logic        entrada0w1;
   logic        entrada1w1;
   logic        selW1;
   logic        salidaW1;
   logic        salidaQW1;
   logic        selQW1;

   int          compareCount;
   int          mismatchCount;

   mux2to1_param dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .entrada0 (entrada0),
      .entrada1 (entrada1),
      .sel      (sel),
      .salida   (salida),
      .salida_q (salidaQ),
      .sel_q    (selQ)
   );

   mux2to1_param #(.WIDTH(8)) dutW8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .entrada0 (entrada0w8),
      .entrada1 (entrada1w8),
      .sel      (selW8),
      .salida   (salidaW8),
      .salida_q (salidaQW8),
      .sel_q    (selQW8)
   );

   mux2to1_param #(.WIDTH(1)) dutW1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .entrada0 (entrada0w1),
      .entrada1 (entrada1w1),
      .sel      (selW1),
      .salida   (salidaW1),
      .salida_q (salidaQW1),
      .sel_q    (selQW1)
   );

   // Clock stays idle low until clkEnable is raised, so the combinational
   // path can first be exercised with no clock activity at all.
   initial begin
      clk = 1'b0;
      wait (clkEnable);
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives the 32-bit instance inputs.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic s);
      entrada0 = a;
      entrada1 = b;
      sel      = s;
   endtask

   logic [7:0] corners [4];
   logic [7:0] expW8;
   logic       expW1;

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      clkEnable     = 1'b0;
      corners[0] = 8'h00;
      corners[1] = 8'hFF;
      corners[2] = 8'h80;
      corners[3] = 8'h01;
      entrada0w8 = '0;
      entrada1w8 = '0;
      selW8      = 1'b0;
      entrada0w1 = 1'b0;
      entrada1w1 = 1'b0;
      selW1      = 1'b0;

      // Combinational path with clock idle and rst_n never driven.
      applyStimulus(32'hAAAAAAAA, 32'h55555555, 1'b0);
      #10 checkOutput("comb_idle_sel0", salida, 32'hAAAAAAAA);
      sel = 1'b1;
      #10 checkOutput("comb_idle_sel1", salida, 32'h55555555);

      applyStimulus(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
      #10 checkOutput("comb_f0_sel0", salida, 32'hF0F0F0F0);
      sel = 1'b1;
      #10 checkOutput("comb_f0_sel1", salida, 32'h0F0F0F0F);

      // Unknown select must fall back to entrada0.
      sel = 1'bx;
      #10 checkOutput("comb_selx", salida, 32'hF0F0F0F0);

      // Equal inputs: result independent of sel.
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      #10 checkOutput("equal_sel0", salida, 32'hFFFFFFFF);
      sel = 1'b1;
      #10 checkOutput("equal_sel1", salida, 32'hFFFFFFFF);

      // Simultaneous sel and data change.
      applyStimulus(32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
      #10 checkOutput("simul_change", salida, 32'hDEADBEEF);

      // Reset with clock running: registers clear without a clock edge.
      clkEnable = 1'b1;
      #12;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_salida_q", salidaQ, 32'h0);
      checkOutput("rst_sel_q", {31'b0, selQ}, 32'h0);
      checkOutput("rst_salida_comb", salida, 32'hDEADBEEF);
      checkOutput("rst_w8_salida_q", {24'b0, salidaQW8}, 32'h0);

      // Registers hold zero across edges while reset is held.
      @(posedge clk);
      #1 checkOutput("rst_hold_salida_q", salidaQ, 32'h0);

      // Release reset with sel = 1, entrada1 = 0x12345678.
      @(negedge clk);
      applyStimulus(32'h0BADF00D, 32'h12345678, 1'b1);
      rst_n = 1'b1;
      #1 checkOutput("pre_edge_salida_q", salidaQ, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("first_edge_salida_q", salidaQ, 32'h12345678);
      checkOutput("first_edge_sel_q", {31'b0, selQ}, 32'h1);

      // Change inputs at negedge: registered outputs lag by one edge.
      @(negedge clk);
      applyStimulus(32'h0BADF00D, 32'h12345678, 1'b0);
      #1 checkOutput("lag_salida_q", salidaQ, 32'h12345678);
      @(posedge clk);
      #1;
      checkOutput("next_edge_salida_q", salidaQ, 32'h0BADF00D);
      checkOutput("next_edge_sel_q", {31'b0, selQ}, 32'h0);

      // Load 0x12345678 again, then reset mid-cycle.
      @(negedge clk);
      sel = 1'b1;
      @(posedge clk);
      #3;
      checkOutput("mid_pre_salida_q", salidaQ, 32'h12345678);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_salida_q", salidaQ, 32'h0);
      checkOutput("mid_rst_sel_q", {31'b0, selQ}, 32'h0);
      checkOutput("mid_rst_salida", salida, 32'h12345678);

      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive 8-bit sweep over sel and corner values.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
               @(negedge clk);
               entrada0w8 = corners[i];
               entrada1w8 = corners[j];
               selW8      = s[0];
               expW8      = (s == 1) ? corners[j] : corners[i];
               #1 checkOutput($sformatf("w8_comb_s%0d_%0d_%0d", s, i, j),
                              {24'b0, salidaW8}, {24'b0, expW8});
               @(posedge clk);
               #1;
               checkOutput($sformatf("w8_reg_s%0d_%0d_%0d", s, i, j),
                           {24'b0, salidaQW8}, {24'b0, expW8});
               checkOutput($sformatf("w8_selq_s%0d_%0d_%0d", s, i, j),
                           {31'b0, selQW8}, {31'b0, s[0]});
            end
         end
      end

      // 1-bit instance: all eight input combinations.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         entrada0w1 = k[0];
         entrada1w1 = k[1];
         selW1      = k[2];
         expW1      = k[2] ? k[1] : k[0];
         #1 checkOutput($sformatf("w1_comb_%0d", k), {31'b0, salidaW1}, {31'b0, expW1});
         @(posedge clk);
         #1;
         checkOutput($sformatf("w1_reg_%0d", k), {31'b0, salidaQW1}, {31'b0, expW1});
         checkOutput($sformatf("w1_selq_%0d", k), {31'b0, selQW1}, {31'b0, k[2]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule : tb_mux2to1_param
